// File: rtl/span_margin_engine_pkg.sv
// span_pkg: shared definitions for the span margin engine.
//   state_t        - calculation sequencer states
//   STAT_*_BIT     - bit positions inside the STATUS register
//   *_base / *_off - register-map offset helpers, parameterised on the
//                    instrument count (n) and tier count (t)
package span_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SPREAD,
        ST_SUM,
        ST_DONE
    } state_t;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_ERR_BIT  = 2;
    localparam int unsigned STAT_OVF_BIT  = 3;

    localparam int unsigned PSR_OFF  = 0;
    localparam int unsigned POS_BASE = 1;

    function automatic int unsigned mat_base(input int unsigned n);
        return 1 + n;
    endfunction

    function automatic int unsigned tmax_base(input int unsigned n);
        return 1 + 2 * n;
    endfunction

    function automatic int unsigned chg_base(input int unsigned n, input int unsigned t);
        return 1 + 2 * n + t;
    endfunction

    function automatic int unsigned ctrl_off(input int unsigned n, input int unsigned t);
        return 1 + 2 * n + 2 * t;
    endfunction

    function automatic int unsigned status_off(input int unsigned n, input int unsigned t);
        return ctrl_off(n, t) + 1;
    endfunction

    function automatic int unsigned scan_off(input int unsigned n, input int unsigned t);
        return ctrl_off(n, t) + 2;
    endfunction

    function automatic int unsigned tsc_off(input int unsigned n, input int unsigned t);
        return ctrl_off(n, t) + 3;
    endfunction

    function automatic int unsigned total_off(input int unsigned n, input int unsigned t);
        return ctrl_off(n, t) + 4;
    endfunction

endpackage

// File: rtl/span_margin_engine_tier_acc.sv
// span_tier_acc: one maturity tier's long/short position accumulators and
// its intra-tier spread term.
//   clk, reset  - clock, synchronous active-high reset
//   clr         - zero both accumulators (start of a calculation)
//   add_en      - add mag into the accumulator selected by add_long
//   add_long    - 1: long side, 0: short side
//   mag         - position magnitude
//   chg         - intra-tier charge per matched unit
//   term        - min(long, short) * chg, full precision
module span_tier_acc #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             add_en,
    input  logic             add_long,
    input  logic [ACC_W-1:0] mag,
    input  logic [7:0]       chg,
    output logic [ACC_W+7:0] term
);

    logic [ACC_W-1:0] long_q;
    logic [ACC_W-1:0] short_q;
    logic [ACC_W-1:0] min_v;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            long_q  <= '0;
            short_q <= '0;
        end else if (add_en) begin
            if (add_long) begin
                long_q <= long_q + mag;
            end else begin
                short_q <= short_q + mag;
            end
        end
    end

    always_comb begin
        min_v = (long_q < short_q) ? long_q : short_q;
        term  = {8'h00, min_v} * {{ACC_W{1'b0}}, chg};
    end

endmodule

// File: rtl/span_margin_engine.sv
// span_margin_engine: register-mapped portfolio margin calculator.
// Scans instrument positions into a net position and per-tier long/short
// totals, then forms the scan risk (|net| * PSR) and the intra-tier spread
// charge (sum of min(long,short) * CHG per tier), saturating to DATA_W bits.
//   clk, reset           - clock, synchronous active-high reset
//   chipselect           - slave select
//   write, read          - register strobes (write wins when both are set)
//   offset, writeData    - word address and write data
//   readData             - registered read data
module span_margin_engine
    import span_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_INST = 8,
    parameter int N_TIER = 3,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] offset,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
);

    localparam int ACC_W  = 2 * DATA_W + 8;
    localparam int TSC_W  = ACC_W + 8;
    localparam int SCAN_W = ACC_W + DATA_W;
    localparam int INST_W = (N_INST > 1) ? $clog2(N_INST) : 1;
    localparam int TIER_W = (N_TIER > 1) ? $clog2(N_TIER) : 1;

    localparam int unsigned MAT_B  = mat_base(N_INST);
    localparam int unsigned TMAX_B = tmax_base(N_INST);
    localparam int unsigned CHG_B  = chg_base(N_INST, N_TIER);
    localparam int unsigned CTRL_O = ctrl_off(N_INST, N_TIER);
    localparam int unsigned STAT_O = status_off(N_INST, N_TIER);
    localparam int unsigned SCAN_O = scan_off(N_INST, N_TIER);
    localparam int unsigned TSC_O  = tsc_off(N_INST, N_TIER);
    localparam int unsigned TOT_O  = total_off(N_INST, N_TIER);

    if (2 * N_INST + 2 * N_TIER + 6 > 2 ** ADDR_W) begin : g_addr_check
        $error("span_margin_engine: ADDR_W too small for the register map");
    end
    if (N_INST < 1 || N_INST > 32 || N_TIER < 1 || N_TIER > 8) begin : g_size_check
        $error("span_margin_engine: N_INST must be 1..32 and N_TIER 1..8");
    end

    // Configuration
    logic [DATA_W-1:0] psr_q;
    logic [DATA_W-1:0] pos_q  [N_INST];
    logic [7:0]        mat_q  [N_INST];
    logic [7:0]        tmax_q [N_TIER];
    logic [7:0]        chg_q  [N_TIER];

    // Sequencer and datapath
    state_t            state_q, state_d;
    logic [INST_W-1:0] inst_idx;
    logic [TIER_W-1:0] tier_idx;
    logic [ACC_W-1:0]  net_q;
    logic [TSC_W-1:0]  tsc_q;
    logic [DATA_W-1:0] scan_res_q, tsc_res_q, total_q;
    logic              done_q, err_q, ovf_q;

    logic              cs_wr, cs_rd, idle_like, busy, cfg_hit, ctrl_hit, start_req;
    logic [DATA_W-1:0] pos_cur;
    logic [ACC_W-1:0]  pos_ext, pos_mag;
    logic              tier_hit;
    logic [TIER_W-1:0] tier_sel;
    logic [N_TIER-1:0] add_en;
    logic [TSC_W-1:0]  tier_term [N_TIER];
    logic [TSC_W-1:0]  term_sel;
    logic [ACC_W-1:0]  abs_net;
    logic [SCAN_W-1:0] scan_full;
    logic [DATA_W-1:0] scan_sat, tsc_sat;
    logic [DATA_W:0]   total_full;
    logic              scan_ovf, tsc_ovf, sum_ovf;
    logic [DATA_W-1:0] status_w, rd_val;

    assign cs_wr     = chipselect & write;
    assign cs_rd     = chipselect & read & ~write;
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy      = ~idle_like;
    // Offsets below CTRL are exactly the configuration registers.
    assign cfg_hit   = offset < ADDR_W'(CTRL_O);
    assign ctrl_hit  = offset == ADDR_W'(CTRL_O);
    assign start_req = cs_wr & ctrl_hit & writeData[0] & idle_like;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start_req) state_d = ST_SCAN;
            ST_SCAN:          if (inst_idx == INST_W'(N_INST - 1)) state_d = ST_SPREAD;
            ST_SPREAD:        if (tier_idx == TIER_W'(N_TIER - 1)) state_d = ST_SUM;
            ST_SUM:           state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Current instrument: sign-extended value, magnitude and tier lookup.
    always_comb begin
        pos_cur  = pos_q[inst_idx];
        pos_ext  = {{(ACC_W - DATA_W){pos_cur[DATA_W-1]}}, pos_cur};
        pos_mag  = pos_cur[DATA_W-1] ? (~pos_ext + ACC_W'(1)) : pos_ext;
        tier_hit = 1'b0;
        tier_sel = '0;
        // Walk downward so the lowest matching tier is the one kept.
        for (int unsigned t = N_TIER; t > 0; t--) begin
            if (mat_q[inst_idx] <= tmax_q[t-1]) begin
                tier_hit = 1'b1;
                tier_sel = TIER_W'(t - 1);
            end
        end
        for (int unsigned t = 0; t < N_TIER; t++) begin
            add_en[t] = (state_q == ST_SCAN) && tier_hit && (tier_sel == TIER_W'(t));
        end
    end

    for (genvar g = 0; g < N_TIER; g++) begin : g_tier
        span_tier_acc #(.ACC_W(ACC_W)) u_acc (
            .clk      (clk),
            .reset    (reset),
            .clr      (start_req),
            .add_en   (add_en[g]),
            .add_long (~pos_cur[DATA_W-1]),
            .mag      (pos_mag),
            .chg      (chg_q[g]),
            .term     (tier_term[g])
        );
    end

    assign term_sel = tier_term[tier_idx];

    // Final results with saturation to DATA_W bits.
    always_comb begin
        abs_net    = net_q[ACC_W-1] ? (~net_q + ACC_W'(1)) : net_q;
        scan_full  = {{DATA_W{1'b0}}, abs_net} * {{ACC_W{1'b0}}, psr_q};
        scan_ovf   = |scan_full[SCAN_W-1:DATA_W];
        tsc_ovf    = |tsc_q[TSC_W-1:DATA_W];
        scan_sat   = scan_ovf ? '1 : scan_full[DATA_W-1:0];
        tsc_sat    = tsc_ovf ? '1 : tsc_q[DATA_W-1:0];
        total_full = {1'b0, scan_sat} + {1'b0, tsc_sat};
        sum_ovf    = scan_ovf | tsc_ovf | total_full[DATA_W];
    end

    always_comb begin
        status_w                = '0;
        status_w[STAT_BUSY_BIT] = busy;
        status_w[STAT_DONE_BIT] = done_q;
        status_w[STAT_ERR_BIT]  = err_q;
        status_w[STAT_OVF_BIT]  = ovf_q;
    end

    always_comb begin
        rd_val = '0;
        if (offset == ADDR_W'(PSR_OFF)) rd_val = psr_q;
        for (int unsigned i = 0; i < N_INST; i++) begin
            if (offset == ADDR_W'(POS_BASE + i)) rd_val = pos_q[i];
            if (offset == ADDR_W'(MAT_B + i))    rd_val = {{(DATA_W-8){1'b0}}, mat_q[i]};
        end
        for (int unsigned t = 0; t < N_TIER; t++) begin
            if (offset == ADDR_W'(TMAX_B + t)) rd_val = {{(DATA_W-8){1'b0}}, tmax_q[t]};
            if (offset == ADDR_W'(CHG_B + t))  rd_val = {{(DATA_W-8){1'b0}}, chg_q[t]};
        end
        if (offset == ADDR_W'(STAT_O)) rd_val = status_w;
        if (offset == ADDR_W'(SCAN_O)) rd_val = scan_res_q;
        if (offset == ADDR_W'(TSC_O))  rd_val = tsc_res_q;
        if (offset == ADDR_W'(TOT_O))  rd_val = total_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q      <= '0;
            for (int unsigned i = 0; i < N_INST; i++) begin
                pos_q[i] <= '0;
                mat_q[i] <= '0;
            end
            for (int unsigned t = 0; t < N_TIER; t++) begin
                tmax_q[t] <= '0;
                chg_q[t]  <= '0;
            end
            inst_idx   <= '0;
            tier_idx   <= '0;
            net_q      <= '0;
            tsc_q      <= '0;
            scan_res_q <= '0;
            tsc_res_q  <= '0;
            total_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            readData   <= '0;
        end else begin
            if (cs_wr && cfg_hit) begin
                if (idle_like) begin
                    if (offset == ADDR_W'(PSR_OFF)) psr_q <= writeData;
                    for (int unsigned i = 0; i < N_INST; i++) begin
                        if (offset == ADDR_W'(POS_BASE + i)) pos_q[i] <= writeData;
                        if (offset == ADDR_W'(MAT_B + i))    mat_q[i] <= writeData[7:0];
                    end
                    for (int unsigned t = 0; t < N_TIER; t++) begin
                        if (offset == ADDR_W'(TMAX_B + t)) tmax_q[t] <= writeData[7:0];
                        if (offset == ADDR_W'(CHG_B + t))  chg_q[t]  <= writeData[7:0];
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (cs_wr && ctrl_hit && writeData[1]) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end

            if (start_req) begin
                inst_idx   <= '0;
                tier_idx   <= '0;
                net_q      <= '0;
                tsc_q      <= '0;
                scan_res_q <= '0;
                tsc_res_q  <= '0;
                total_q    <= '0;
                ovf_q      <= 1'b0;
                done_q     <= 1'b0;
            end

            unique case (state_q)
                ST_SCAN: begin
                    net_q    <= net_q + pos_ext;
                    inst_idx <= inst_idx + INST_W'(1);
                end
                ST_SPREAD: begin
                    tsc_q    <= tsc_q + term_sel;
                    tier_idx <= tier_idx + TIER_W'(1);
                end
                ST_SUM: begin
                    scan_res_q <= scan_sat;
                    tsc_res_q  <= tsc_sat;
                    total_q    <= total_full[DATA_W] ? '1 : total_full[DATA_W-1:0];
                    ovf_q      <= sum_ovf;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase

            if (cs_rd) readData <= rd_val;
        end
    end

endmodule

// File: tb/tb_span_margin_engine.sv
// Directed bench for span_margin_engine with default parameters
// (8 instruments, 3 tiers): register map 0 PSR, 1-8 POS, 9-16 MAT,
// 17-19 TMAX, 20-22 CHG, 23 CTRL, 24 STATUS, 25 SCAN, 26 TSC, 27 TOTAL.
module tb_span_margin_engine;

    localparam logic [5:0] O_PSR  = 6'd0;
    localparam logic [5:0] O_POS0 = 6'd1;
    localparam logic [5:0] O_MAT0 = 6'd9;
    localparam logic [5:0] O_TMX0 = 6'd17;
    localparam logic [5:0] O_CHG0 = 6'd20;
    localparam logic [5:0] O_CTRL = 6'd23;
    localparam logic [5:0] O_STAT = 6'd24;
    localparam logic [5:0] O_SCAN = 6'd25;
    localparam logic [5:0] O_TSC  = 6'd26;
    localparam logic [5:0] O_TOT  = 6'd27;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [5:0]  offset = '0;
    logic [15:0] writeData = '0;
    logic [15:0] readData;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    span_margin_engine #(.DATA_W(16), .N_INST(8), .N_TIER(3), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .offset     (offset),
        .writeData  (writeData),
        .readData   (readData)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [5:0] off, input logic [15:0] data);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        offset = off; writeData = data;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] off, output logic [15:0] v);
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        offset = off;
        step();
        v = readData;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic [15:0] v);
        v = '0;
        for (int i = 0; i < 40; i++) begin
            rd(O_STAT, v);
            if (v[1]) break;
        end
        if (!v[1]) chk({tag, "_timeout"}, v, 16'h0002);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] off, input logic [15:0] exp);
        logic [15:0] v;
        rd(off, v);
        chk(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;

        // Reset state
        do_reset();
        chk("rst_readData", readData, 16'h0000);
        rd_chk("rst_status", O_STAT, 16'h0000);
        rd_chk("rst_psr", O_PSR, 16'h0000);

        // Basic portfolio: net 2 * 100, tier0 min(5,3)*10
        wr(O_PSR, 16'd100);
        wr(O_POS0, 16'd5);
        wr(O_POS0 + 6'd1, 16'hFFFD);
        wr(O_MAT0, 16'd1);
        wr(O_MAT0 + 6'd1, 16'd2);
        wr(O_TMX0, 16'd3);
        wr(O_CHG0, 16'd10);
        wr(O_CHG0 + 6'd2, 16'h01AB);
        rd_chk("narrow_chg2", O_CHG0 + 6'd2, 16'h00AB);
        rd_chk("pos1_rb", O_POS0 + 6'd1, 16'hFFFD);

        // Start; each read returns STATUS of the cycle it was issued in.
        wr(O_CTRL, 16'h0001);
        for (int k = 1; k <= 13; k++) begin
            rd(O_STAT, v);
            chk($sformatf("lat_c%0d", k), v, (k < 13) ? 16'h0001 : 16'h0002);
        end
        rd_chk("basic_scan", O_SCAN, 16'd200);
        rd_chk("basic_tsc", O_TSC, 16'd30);
        rd_chk("basic_total", O_TOT, 16'd230);

        // Restart from DONE with unchanged config
        wr(O_CTRL, 16'h0001);
        rd_chk("rerun_busy", O_STAT, 16'h0001);
        rd_chk("rerun_scan_clr", O_SCAN, 16'h0000);
        wait_done("rerun", v);
        chk("rerun_status", v, 16'h0002);
        rd_chk("rerun_scan", O_SCAN, 16'd200);
        rd_chk("rerun_tsc", O_TSC, 16'd30);
        rd_chk("rerun_total", O_TOT, 16'd230);

        // Read and write together: write lands, readData holds
        rd_chk("rw_pre", O_PSR, 16'd100);
        chipselect = 1'b1; write = 1'b1; read = 1'b1;
        offset = O_PSR; writeData = 16'd55;
        step();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        chk("rw_hold", readData, 16'd100);
        rd_chk("rw_psr", O_PSR, 16'd55);

        // Writes to result, status and unmapped offsets are ignored
        wr(O_SCAN, 16'h1234);
        rd_chk("wr_result_ign", O_SCAN, 16'd200);
        wr(O_STAT, 16'h000F);
        rd_chk("wr_status_ign", O_STAT, 16'h0002);
        wr(6'd40, 16'h5555);
        rd_chk("unmapped_rd", 6'd40, 16'h0000);

        // Config write while busy -> ignored, err; CTRL clear
        wr(O_CTRL, 16'h0001);
        wr(O_POS0 + 6'd2, 16'd7);
        wait_done("err", v);
        chk("err_status", v, 16'h0006);
        rd_chk("err_pos2", O_POS0 + 6'd2, 16'h0000);
        wr(O_CTRL, 16'h0002);
        rd_chk("clr_status", O_STAT, 16'h0000);

        // Saturation
        do_reset();
        wr(O_POS0, 16'h7FFF);
        wr(O_PSR, 16'h7FFF);
        wr(O_CTRL, 16'h0001);
        wait_done("sat", v);
        chk("sat_status", v, 16'h000A);
        rd_chk("sat_scan", O_SCAN, 16'hFFFF);
        rd_chk("sat_tsc", O_TSC, 16'h0000);
        rd_chk("sat_total", O_TOT, 16'hFFFF);

        // Maturity beyond every tier bound: net only
        do_reset();
        wr(O_MAT0, 16'd20);
        wr(O_POS0, 16'd4);
        wr(O_PSR, 16'd5);
        wr(O_CTRL, 16'h0001);
        wait_done("nomatch", v);
        chk("nomatch_status", v, 16'h0002);
        rd_chk("nomatch_scan", O_SCAN, 16'd20);
        rd_chk("nomatch_tsc", O_TSC, 16'd0);
        rd_chk("nomatch_total", O_TOT, 16'd20);

        // Reset during SPREAD
        do_reset();
        wr(O_PSR, 16'd9);
        wr(O_POS0, 16'd1);
        wr(O_CTRL, 16'h0001);
        rd_chk("midrst_psr_pre", O_PSR, 16'd9);
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_readData", readData, 16'h0000);
        rd_chk("midrst_status", O_STAT, 16'h0000);
        repeat (5) step();
        rd_chk("midrst_status_late", O_STAT, 16'h0000);
        rd_chk("midrst_scan", O_SCAN, 16'h0000);
        rd_chk("midrst_total", O_TOT, 16'h0000);
        rd_chk("midrst_psr", O_PSR, 16'h0000);

        // Reset coincident with start: no calculation
        wr(O_PSR, 16'd3);
        wr(O_POS0, 16'd1);
        reset = 1'b1;
        chipselect = 1'b1; write = 1'b1; offset = O_CTRL; writeData = 16'h0001;
        step();
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        rd_chk("rststart_busy", O_STAT, 16'h0000);
        repeat (15) step();
        rd_chk("rststart_status", O_STAT, 16'h0000);
        rd_chk("rststart_scan", O_SCAN, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
